ascon_block_packer: RTL

//  Upstream feeder for the ASCON AEAD core: packs a byte stream into 64-bit rate blocks.

---
 rtl/ascon_pkg.sv | 13 +
 rtl/ascon_block_fifo.sv | 56 +++++
 rtl/ascon_block_packer.sv | 104 ++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared constants and block type for the ASCON rate-block feeder.
package ascon_pkg;

   localparam int unsigned ASCON_RATE_BYTES = 8;
   localparam int unsigned ASCON_RATE_BITS  = 64;

   typedef struct packed {
      logic [63:0] data;
      logic [3:0]  len;
      logic        last;
   } ascon_blk_t;

endpackage

// File: rtl/ascon_block_fifo.sv
// Small synchronous FIFO of packed rate blocks; head reads as all-zero when empty.
module ascon_block_fifo
   import ascon_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  ascon_blk_t               push_blk,
   input  logic                     pop,
   output ascon_blk_t               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   ascon_blk_t          mem_q [DEPTH];
   logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]       level_q, level_d;

   always_comb begin
      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         level_q <= level_d;
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_ptr_q] <= push_blk;
   end

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ascon_block_packer.sv
// Packs a byte stream into 64-bit ASCON rate blocks with byte counts and queues them for the core.
module ascon_block_packer
   import ascon_pkg::*;
#(
   parameter int unsigned DEPTH           = 2,
   parameter bit          PAD_EMPTY_BLOCK = 1'b1
) (
   input  logic                     clk,
   input  logic                     RST,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   input  logic                     in_last,
   input  logic                     in_empty,
   output logic                     in_ready,
   input  logic                     read,
   output logic [63:0]              blockin,
   output logic [3:0]               datalen,
   output logic                     blk_last,
   output logic                     blk_valid,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     underflow
);

   logic [ASCON_RATE_BITS-1:0] acc_q, acc_d, acc_wr;
   logic [2:0]                 cnt_q, cnt_d;
   logic [3:0]                 cnt_inc;
   logic                       pend_q, pend_d;
   logic                       underflow_q;
   logic                       accept, fifo_push, fifo_pop, fifo_full, fifo_empty;
   ascon_blk_t                 push_blk, head;

   assign in_ready = !RST && !fifo_full && !pend_q;
   assign accept   = in_valid && in_ready;
   assign fifo_pop = read && !fifo_empty;

   always_comb begin
      acc_wr    = acc_q | ({in_data, 56'd0} >> {cnt_q, 3'b000});
      cnt_inc   = {1'b0, cnt_q} + 4'd1;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      fifo_push = 1'b0;
      push_blk  = '0;
      if (pend_q) begin
         // Trailing empty block after a full final block; waits for FIFO space.
         if (!fifo_full) begin
            fifo_push     = 1'b1;
            push_blk.last = 1'b1;
            pend_d        = 1'b0;
         end
      end else if (accept) begin
         if (in_last && in_empty) begin
            fifo_push     = PAD_EMPTY_BLOCK;
            push_blk.last = PAD_EMPTY_BLOCK;
         end else if (cnt_inc == 4'(ASCON_RATE_BYTES) || in_last) begin
            fifo_push     = 1'b1;
            push_blk.data = acc_wr;
            push_blk.len  = cnt_inc;
            push_blk.last = in_last && (cnt_inc < 4'(ASCON_RATE_BYTES) || !PAD_EMPTY_BLOCK);
            acc_d         = '0;
            cnt_d         = '0;
            pend_d        = in_last && cnt_inc == 4'(ASCON_RATE_BYTES) && PAD_EMPTY_BLOCK;
         end else begin
            acc_d = acc_wr;
            cnt_d = cnt_inc[2:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         if (read && fifo_empty) underflow_q <= 1'b1;
      end
   end

   ascon_block_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (RST),
      .push     (fifo_push),
      .push_blk (push_blk),
      .pop      (fifo_pop),
      .head     (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (level)
   );

   assign blockin   = head.data;
   assign datalen   = head.len;
   assign blk_last  = head.last;
   assign blk_valid = !fifo_empty;
   assign underflow = underflow_q;

endmodule
